tt_sweep_checker: RTL and testbench
===================================

Name: tt_sweep_checker

Overview:
- Sequential stage that sits directly upstream and downstream of the 5-input combinational function stage.
- Drives every 5-bit input vector 0..31 onto a shared input bus. Two implementations of the function (canonical sum-of-minterms and minimised form) consume that bus.
- Samples both implementations' outputs and builds the 32-entry truth table of implementation A.
- Counts A/B disagreements, records the first disagreeing vector, and reports pass/fail through a start/done handshake.

Parameters:
SETTLE, 1, wait cycles after a new vector is driven before sampling (legal 0..15)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request a sweep; accepted only in IDLE
vec_out  output  5  vector driven to both function implementations
f_a  input  1  output of implementation A (canonical form)
f_b  input  1  output of implementation B (minimised form)
busy  output  1  high from the cycle after start is accepted through the last sample cycle
done  output  1  one-cycle pulse when the sweep completes
truth_tbl  output  32  bit i = f_a sampled at vector i
mismatch_cnt  output  6  number of vectors with f_a != f_b (0..32)
first_bad  output  5  lowest vector index with f_a != f_b
first_bad_vld  output  1  first_bad holds a valid index
pass  output  1  high after done when mismatch_cnt == 0; held until next accepted start

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n low at a rising edge):
  - state = IDLE.
  - vec_out, busy, done, truth_tbl, mismatch_cnt, first_bad, first_bad_vld, pass all = 0.
  - Reset overrides start and aborts any sweep in progress. No partial results are kept.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - busy = 0.
  - start = 1 at an edge → go to WAIT. Same edge:
    - vec_out = 0, settle counter = SETTLE.
    - truth_tbl, mismatch_cnt, first_bad, first_bad_vld, pass cleared.
- WAIT:
  - Counter > 0 → decrement.
  - Counter == 0 → go to SAMPLE.
  - With SETTLE = 0, WAIT lasts exactly one cycle and is never skipped.
- SAMPLE (one cycle). At the edge leaving SAMPLE:
  - truth_tbl[vec_out] = f_a.
  - If f_a != f_b: mismatch_cnt += 1. If first_bad_vld == 0, also set first_bad = vec_out and first_bad_vld = 1.
  - If vec_out == 31 → go to DONE.
  - Otherwise vec_out += 1, counter reloaded with SETTLE, go to WAIT.
- Timing per vector: each vector is held for SETTLE+2 cycles (SETTLE+1 in WAIT, 1 in SAMPLE). f_a and f_b are sampled only in SAMPLE.
- DONE (one cycle):
  - done = 1, busy = 0.
  - pass = (mismatch_cnt == 0).
  - vec_out holds 31.
  - Next state IDLE.
- Results: all results stay stable in IDLE until the next accepted start.
- Latency: first DONE cycle is 32*(SETTLE+2)+1 cycles after the start-accept edge.
  - SETTLE = 0 → 65 cycles.
  - SETTLE = 1 → 97 cycles.
- start handling: start in WAIT, SAMPLE or DONE is ignored, with no queuing. A start held high across DONE→IDLE launches a new sweep from IDLE on the next edge.
- Counters: mismatch_cnt saturates naturally at 32 and cannot exceed 32. vec_out never wraps past 31 within a sweep.
- Sampling: f_a and f_b are synchronous to clk; no resynchronisation is applied.

Test Plan:
- SETTLE=1; f_a = f_b = vec_out[0]; pulse start → done 97 cycles later; truth_tbl = 32'hAAAAAAAA, mismatch_cnt = 0, first_bad_vld = 0, pass = 1.
- f_a = vec_out[0]; f_b = vec_out[0] except inverted at vec_out = 9 and at vec_out = 20 → mismatch_cnt = 2, first_bad = 9, first_bad_vld = 1, pass = 0.
- f_a = 1, f_b = 0 constant → truth_tbl = 32'hFFFFFFFF, mismatch_cnt = 32, first_bad = 0, pass = 0.
- SETTLE=0; start → vec_out advances every 2 cycles (0,0,1,1,…); done pulses exactly 65 cycles after the accept edge, for exactly 1 cycle.
- Start re-pulsed during the sweep at vector 12 → ignored; single done pulse at the normal time; results identical to a clean run.
- rst_n low for 1 cycle at vector 17 → next cycle: state IDLE, all outputs 0, no done pulse. A fresh start then completes normally with correct results.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// Sweeps all 32 vectors of a 5-input function through two implementations, builds A's truth table and compares A against B.
// Latency: DONE is 32*(SETTLE+2)+1 cycles after start is accepted; start is honoured only in IDLE and is never queued.
module tt_sweep_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  vec_out,
    input  logic        f_a,
    input  logic        f_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] truth_tbl,
    output logic [5:0]  mismatch_cnt,
    output logic [4:0]  first_bad,
    output logic        first_bad_vld,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t     state;
    logic [3:0] settle_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            vec_out       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            truth_tbl     <= '0;
            mismatch_cnt  <= '0;
            first_bad     <= '0;
            first_bad_vld <= 1'b0;
            pass          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= WAIT;
                        vec_out       <= '0;
                        settle_cnt    <= SETTLE_L;
                        busy          <= 1'b1;
                        truth_tbl     <= '0;
                        mismatch_cnt  <= '0;
                        first_bad     <= '0;
                        first_bad_vld <= 1'b0;
                        pass          <= 1'b0;
                    end
                end
                // Always at least one WAIT cycle, even with SETTLE = 0.
                WAIT: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    truth_tbl[vec_out] <= f_a;
                    if (f_a != f_b) begin
                        mismatch_cnt <= mismatch_cnt + 6'd1;
                        if (!first_bad_vld) begin
                            first_bad     <= vec_out;
                            first_bad_vld <= 1'b1;
                        end
                    end
                    if (vec_out == 5'd31) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        vec_out    <= vec_out + 5'd1;
                        settle_cnt <= SETTLE_L;
                        state      <= WAIT;
                    end
                end
                DONE: begin
                    // mismatch_cnt is final here, so pass is safe to derive now.
                    pass  <= (mismatch_cnt == 6'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench: two checkers (SETTLE=1 and SETTLE=0) driven by small function models selected per test.
module tb_tt_sweep_checker;

    logic        clk;
    logic        rst_n;
    logic        start1, start0;
    logic [4:0]  vec1, vec0;
    logic        fa1, fb1, fa0, fb0;
    logic        busy1, busy0, done1, done0;
    logic [31:0] tbl1, tbl0;
    logic [5:0]  cnt1, cnt0;
    logic [4:0]  bad1, bad0;
    logic        badv1, badv0, pass1, pass0;
    int          mode1, mode0;

    int n_cmp;
    int n_bad;

    tt_sweep_checker #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .vec_out(vec1),
        .f_a(fa1), .f_b(fb1), .busy(busy1), .done(done1),
        .truth_tbl(tbl1), .mismatch_cnt(cnt1), .first_bad(bad1),
        .first_bad_vld(badv1), .pass(pass1)
    );

    tt_sweep_checker #(.SETTLE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .vec_out(vec0),
        .f_a(fa0), .f_b(fb0), .busy(busy0), .done(done0),
        .truth_tbl(tbl0), .mismatch_cnt(cnt0), .first_bad(bad0),
        .first_bad_vld(badv0), .pass(pass0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {f_a, f_b}: 0 = both vec[0]; 1 = B inverted at 9 and 20; 2 = A=1, B=0.
    function automatic logic [1:0] fpair(input int mode, input logic [4:0] v);
        logic a, b;
        a = v[0];
        b = v[0];
        if (mode == 1 && (v == 5'd9 || v == 5'd20)) b = ~v[0];
        if (mode == 2) begin
            a = 1'b1;
            b = 1'b0;
        end
        return {a, b};
    endfunction

    always_comb {fa1, fb1} = fpair(mode1, vec1);
    always_comb {fa0, fb0} = fpair(mode0, vec0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sweep on u1; optionally re-pulse start while vec_out == rep. Returns cycle of done (1 = cycle after accept).
    task automatic sweep1(input int mode, input int rep, output int cyc, output int seq_err);
        bit pulsed;
        pulsed  = 0;
        seq_err = 0;
        mode1   = mode;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        cyc = 1;
        check("busy_after_accept", 32'(busy1), 32'd1);
        while (!done1 && cyc < 200) begin
            if (32'(vec1) != (cyc - 1) / 3) seq_err++;
            if (rep >= 0 && !pulsed && 32'(vec1) == rep) begin
                start1 = 1'b1;
                pulsed = 1;
            end
            @(posedge clk);
            #1 start1 = 1'b0;
            cyc++;
        end
    endtask

    initial begin
        int cyc, serr;
        n_cmp  = 0;
        n_bad  = 0;
        mode1  = 0;
        mode0  = 0;
        start1 = 1'b0;
        start0 = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vec", 32'(vec1), 32'd0);
        check("rst_busy_done", {30'd0, busy1, done1}, 32'd0);
        check("rst_tbl", tbl1, 32'd0);
        check("rst_cnt_bad_pass", {18'd0, cnt1, bad1, badv1, pass1}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Test 1: A == B == vec[0]
        sweep1(0, -1, cyc, serr);
        check("t1_done_cycle", 32'(cyc), 32'd97);
        check("t1_vec_seq_errs", 32'(serr), 32'd0);
        check("t1_busy_in_done", 32'(busy1), 32'd0);
        check("t1_vec_in_done", 32'(vec1), 32'd31);
        @(posedge clk);
        #1;
        check("t1_done_width", 32'(done1), 32'd0);
        check("t1_tbl", tbl1, 32'hAAAAAAAA);
        check("t1_cnt", 32'(cnt1), 32'd0);
        check("t1_badv", 32'(badv1), 32'd0);
        check("t1_pass", 32'(pass1), 32'd1);

        // Test 2: two disagreements
        sweep1(1, -1, cyc, serr);
        check("t2_done_cycle", 32'(cyc), 32'd97);
        @(posedge clk);
        #1;
        check("t2_tbl", tbl1, 32'hAAAAAAAA);
        check("t2_cnt", 32'(cnt1), 32'd2);
        check("t2_first_bad", 32'(bad1), 32'd9);
        check("t2_badv", 32'(badv1), 32'd1);
        check("t2_pass", 32'(pass1), 32'd0);

        // Test 3: disagree everywhere
        sweep1(2, -1, cyc, serr);
        @(posedge clk);
        #1;
        check("t3_tbl", tbl1, 32'hFFFFFFFF);
        check("t3_cnt", 32'(cnt1), 32'd32);
        check("t3_first_bad", 32'(bad1), 32'd0);
        check("t3_badv", 32'(badv1), 32'd1);
        check("t3_pass", 32'(pass1), 32'd0);

        // Test 4: SETTLE=0 timing on u0
        mode0 = 0;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        cyc  = 1;
        serr = 0;
        while (!done0 && cyc < 200) begin
            if (32'(vec0) != (cyc - 1) / 2) serr++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("t4_done_cycle", 32'(cyc), 32'd65);
        check("t4_vec_seq_errs", 32'(serr), 32'd0);
        @(posedge clk);
        #1;
        check("t4_done_width", 32'(done0), 32'd0);
        check("t4_tbl", tbl0, 32'hAAAAAAAA);
        check("t4_pass", 32'(pass0), 32'd1);

        // Test 5: start re-pulsed at vector 12 is ignored
        sweep1(1, 12, cyc, serr);
        check("t5_done_cycle", 32'(cyc), 32'd97);
        check("t5_vec_seq_errs", 32'(serr), 32'd0);
        @(posedge clk);
        #1;
        check("t5_cnt", 32'(cnt1), 32'd2);
        check("t5_first_bad", 32'(bad1), 32'd9);
        check("t5_tbl", tbl1, 32'hAAAAAAAA);
        cyc = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (done1) cyc++;
        end
        check("t5_no_extra_done", 32'(cyc), 32'd0);

        // Test 6: reset mid-sweep at vector 17, then clean rerun
        mode1 = 2;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        cyc = 0;
        while (vec1 != 5'd17 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("t6_reached_17", 32'(vec1), 32'd17);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("t6_rst_vec", 32'(vec1), 32'd0);
        check("t6_rst_flags", {30'd0, busy1, done1}, 32'd0);
        check("t6_rst_tbl", tbl1, 32'd0);
        check("t6_rst_cnt_bad_pass", {18'd0, cnt1, bad1, badv1, pass1}, 32'd0);
        cyc = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) cyc++;
        end
        check("t6_stays_idle", 32'(cyc), 32'd0);
        sweep1(1, -1, cyc, serr);
        check("t6_done_cycle", 32'(cyc), 32'd97);
        @(posedge clk);
        #1;
        check("t6_cnt", 32'(cnt1), 32'd2);
        check("t6_first_bad", 32'(bad1), 32'd9);
        check("t6_pass", 32'(pass1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
